// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: turns single-register write/read requests into a
// sequence of byte-level commands for the I2C bit engine (START, WRITE,
// READ, STOP). It gathers the slave ACK/NACK status and the read data, and
// returns one response per request.
// Optional feature macro: I2C_SEQ_TIMEOUT_EN. When it is defined, a
// watchdog on eng_done aborts the engine and reports error 11.
module i2c_txn_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_data,
  output logic       cmd_nack,
  input  logic       eng_done,
  input  logic       eng_ack,
  input  logic [7:0] eng_rdata,
  output logic       eng_abort
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_REG, S_DATA,
    S_RSTART, S_DEV_R, S_READ, S_STOP, S_RESP
  } state_t;

  typedef enum logic {PH_ISSUE, PH_WAIT} phase_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ADDR    = 2'b01;
  localparam logic [1:0] ERR_DATA    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t     state;
  phase_t     phase;
  logic       rw;
  logic [6:0] dev;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [1:0] err;

  state_t     done_next;
  logic [1:0] nack_err;

  // Engine opcode for the command that a given state issues.
  function automatic logic [1:0] op_of(input state_t s);
    logic [1:0] op;
    case (s)
      S_START, S_RSTART: op = OP_START;
      S_READ:            op = OP_READ;
      S_STOP:            op = OP_STOP;
      default:           op = OP_WRITE;
    endcase
    return op;
  endfunction

  // Byte that goes with the command of a given state (0 for non-WRITE).
  function automatic logic [7:0] data_of(input state_t s, input logic [6:0] d,
                                         input logic [7:0] r, input logic [7:0] w);
    logic [7:0] b;
    case (s)
      S_DEV_W: b = {d, 1'b0};
      S_REG:   b = r;
      S_DATA:  b = w;
      S_DEV_R: b = {d, 1'b1};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Where to go once the current command reports done, and which error a NACK raises.
  always_comb begin
    done_next = S_IDLE;
    nack_err  = ERR_OK;
    case (state)
      S_START:  done_next = S_DEV_W;
      S_DEV_W:  begin
        done_next = eng_ack ? S_REG : S_STOP;
        nack_err  = eng_ack ? ERR_OK : ERR_ADDR;
      end
      S_REG:    begin
        done_next = !eng_ack ? S_STOP : (rw ? S_RSTART : S_DATA);
        nack_err  = eng_ack ? ERR_OK : ERR_DATA;
      end
      S_DATA:   begin
        done_next = S_STOP;
        nack_err  = eng_ack ? ERR_OK : ERR_DATA;
      end
      S_RSTART: done_next = S_DEV_R;
      S_DEV_R:  begin
        done_next = eng_ack ? S_READ : S_STOP;
        nack_err  = eng_ack ? ERR_OK : ERR_ADDR;
      end
      S_READ:   done_next = S_STOP;
      S_STOP:   done_next = S_RESP;
      default:  done_next = S_IDLE;
    endcase
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign eng_abort = 1'b0;
`endif

  // Sequencer FSM: accept request, issue/wait per command, return the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= PH_ISSUE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= ERR_OK;
      rsp_rdata <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_START;
      cmd_data  <= 8'h00;
      cmd_nack  <= 1'b0;
      rw        <= 1'b0;
      dev       <= 7'h00;
      reg_addr  <= 8'h00;
      wdata     <= 8'h00;
      rdata     <= 8'h00;
      err       <= ERR_OK;
`ifdef I2C_SEQ_TIMEOUT_EN
      wait_cnt  <= 16'h0000;
      eng_abort <= 1'b0;
`endif
    end else begin
`ifdef I2C_SEQ_TIMEOUT_EN
      eng_abort <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            rw        <= req_rw;
            dev       <= req_dev;
            reg_addr  <= req_reg;
            wdata     <= req_wdata;
            rdata     <= 8'h00;
            err       <= ERR_OK;
            req_ready <= 1'b0;
            state     <= S_START;
            phase     <= PH_ISSUE;
            cmd_valid <= 1'b1;
            cmd_op    <= OP_START;
            cmd_data  <= 8'h00;
            cmd_nack  <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= ERR_OK;
            rsp_rdata <= 8'h00;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          if (phase == PH_ISSUE) begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              phase     <= PH_WAIT;
`ifdef I2C_SEQ_TIMEOUT_EN
              wait_cnt  <= 16'h0000;
`endif
            end
          end else if (eng_done) begin
            if (state == S_READ) rdata <= eng_rdata;
            if (err == ERR_OK) err <= nack_err;
            state <= done_next;
            phase <= PH_ISSUE;
            if (done_next == S_RESP) begin
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_rdata <= (err == ERR_OK) ? rdata : 8'h00;
            end else begin
              cmd_valid <= 1'b1;
              cmd_op    <= op_of(done_next);
              cmd_data  <= data_of(done_next, dev, reg_addr, wdata);
              cmd_nack  <= (done_next == S_READ);
            end
          end
`ifdef I2C_SEQ_TIMEOUT_EN
          else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            eng_abort <= 1'b1;
            state     <= S_RESP;
            phase     <= PH_ISSUE;
            rsp_valid <= 1'b1;
            rsp_err   <= (err == ERR_OK) ? ERR_TIMEOUT : err;
            rsp_rdata <= 8'h00;
          end else begin
            wait_cnt <= wait_cnt + 16'h0001;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: scoreboard bench for i2c_txn_sequencer. A
// behavioural engine answers the commands. Expected commands and responses
// are queued when a request is issued. Monitors pop these queues and compare.
module tb_i2c_txn_sequencer;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;
  logic       cmd_valid, cmd_ready = 1'b0;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       eng_done = 1'b0, eng_ack = 1'b0;
  logic [7:0] eng_rdata = 8'h00;
  logic       eng_abort;

  i2c_txn_sequencer #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_nack(cmd_nack), .eng_done(eng_done), .eng_ack(eng_ack), .eng_rdata(eng_rdata),
    .eng_abort(eng_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  logic [10:0] exp_cmd[$];
  logic [9:0]  exp_rsp[$];
  bit          ack_q[$];
  logic [7:0]  rd_q[$];

  bit zero_wait = 1'b0;
  int cmd_stall_force = -1;
  int rsp_stall_force = -1;
  int spur_pct = 30;
  int hold_at = -1;
  int hs_count = 0;
  int hs_cyc = 0;
  int abort_cnt = 0;
  int abort_cyc = 0;
  int rise_cyc = 0;
  int accept_cyc = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired, got nothing, required an event", name);
  endtask

  function automatic logic [10:0] enc(input logic [1:0] op, input logic [7:0] d, input logic n);
    return {op, d, n};
  endfunction

  // Present one request and hold it until accepted, then scramble the fields.
  task automatic drive_request(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                               input logic [7:0] wd);
    int g;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) fail_now("req_accept");
    accept_cyc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_rw = 1'($urandom_range(0, 1));
    req_dev = 7'($urandom);
    req_reg = 8'($urandom);
    req_wdata = 8'($urandom);
  endtask

  // Reference model: byte sequence, ACK plan and response derived from the request.
  task automatic apply_stimulus(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                                input logic [7:0] wd, input int nack_at, input logic [7:0] rd);
    logic [7:0] bytes[3];
    logic [1:0] codes[3];
    logic [1:0] err;
    logic [7:0] rdata;
    bytes = '{{dev, 1'b0}, rg, rw ? {dev, 1'b1} : wd};
    codes = '{2'b01, 2'b10, rw ? 2'b01 : 2'b10};
    err = 2'b00;
    rdata = 8'h00;
    exp_cmd.push_back(enc(OP_START, 8'h00, 1'b0));
    for (int i = 0; i < 3; i++) begin
      if (rw && i == 2) exp_cmd.push_back(enc(OP_START, 8'h00, 1'b0));
      exp_cmd.push_back(enc(OP_WRITE, bytes[i], 1'b0));
      if (nack_at == i + 1) begin
        ack_q.push_back(1'b0);
        err = codes[i];
        break;
      end
      ack_q.push_back(1'b1);
    end
    if (rw && err == 2'b00) begin
      exp_cmd.push_back(enc(OP_READ, 8'h00, 1'b1));
      rd_q.push_back(rd);
      rdata = rd;
    end
    exp_cmd.push_back(enc(OP_STOP, 8'h00, 1'b0));
    exp_rsp.push_back({err, rdata});
    drive_request(rw, dev, rg, wd);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_rsp.size() != 0 || exp_cmd.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) fail_now("drain");
    @(negedge clk);
  endtask

  // Behavioural engine: accepts commands, answers with done/ack/rdata, checks the command stream.
  initial begin : engine
    bit busy, pending;
    int delay, stall, cur_idx;
    logic [1:0] cur_op;
    logic [10:0] held, e;
    busy = 0; pending = 0; delay = 0; stall = 0; cur_idx = 0; cur_op = OP_START; held = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      eng_ack = 1'($urandom_range(0, 1));
      eng_rdata = 8'($urandom);
      if (reset) begin
        busy = 0; pending = 0; stall = 0; cmd_ready = 1'b0;
      end else begin
        if (eng_abort) begin
          busy = 0;
          abort_cnt++;
          abort_cyc = cyc;
        end
        if (busy && cur_idx != hold_at) begin
          if (delay == 0) begin
            eng_done = 1'b1;
            if (cur_op == OP_WRITE) eng_ack = (ack_q.size() != 0) ? ack_q.pop_front() : 1'b1;
            if (cur_op == OP_READ) eng_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
            busy = 0;
          end else delay--;
        end
        if (pending) begin
          check_output("cmd_valid_held", 32'(cmd_valid), 32'd1);
          check_output("cmd_stable", 32'({cmd_op, cmd_data, cmd_nack}), 32'(held));
        end
        if (cmd_valid) begin
          if (!pending)
            stall = zero_wait ? 0 : (cmd_stall_force >= 0 ? cmd_stall_force :
                    ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0));
          cmd_ready = (stall == 0);
          if (stall > 0) stall--;
          if (cmd_ready) begin
            if (exp_cmd.size() == 0) begin
              n_vec++; n_fail++;
              $display("[TB] FAIL cmd_unexpected: got op %0d data 0x%02h, required no command",
                       cmd_op, cmd_data);
            end else begin
              e = exp_cmd.pop_front();
              check_output("cmd_stream", 32'({cmd_op, cmd_data, cmd_nack}), 32'(e));
            end
            busy = 1; cur_op = cmd_op; cur_idx = hs_count; hs_count++; hs_cyc = cyc + 1;
            delay = zero_wait ? 0 : int'($urandom_range(0, 3));
            pending = 0;
          end else begin
            pending = 1;
            held = {cmd_op, cmd_data, cmd_nack};
            if (!busy && !eng_done && int'($urandom_range(0, 99)) < spur_pct) begin
              eng_done = 1'b1;
              eng_ack = 1'b0;
            end
          end
        end else begin
          cmd_ready = 1'($urandom_range(0, 1));
          pending = 0;
        end
      end
    end
  end

  // Response monitor: drives rsp_ready, pops expected responses and compares.
  initial begin : rsp_mon
    bit prev;
    int stall;
    logic [9:0] e;
    prev = 0; stall = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 0; stall = 0; rsp_ready = 1'b0;
      end else begin
        if (prev) check_output("rsp_valid_held", 32'(rsp_valid), 32'd1);
        if (rsp_valid) begin
          check_output("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (!prev) begin
            rise_cyc = cyc;
            stall = zero_wait ? 0 : (rsp_stall_force >= 0 ? rsp_stall_force :
                                     int'($urandom_range(0, 2)));
          end
          rsp_ready = (stall == 0);
          if (stall > 0) stall--;
          if (rsp_ready) begin
            if (exp_rsp.size() == 0) begin
              n_vec++; n_fail++;
              $display("[TB] FAIL rsp_unexpected: got err %0d rdata 0x%02h, required none",
                       rsp_err, rsp_rdata);
            end else begin
              e = exp_rsp.pop_front();
              check_output("rsp_err", 32'(rsp_err), 32'(e[9:8]));
              check_output("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
            end
`ifndef I2C_SEQ_TIMEOUT_EN
            check_output("eng_abort_zero", 32'(eng_abort), 32'd0);
`endif
            prev = 0;
          end else prev = 1;
        end else begin
          rsp_ready = 1'($urandom_range(0, 1));
          prev = 0;
        end
      end
    end
  end

  task automatic check_reset_values();
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_output("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_output("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_output("rst_cmd_op", 32'(cmd_op), 32'd0);
    check_output("rst_cmd_data", 32'(cmd_data), 32'd0);
    check_output("rst_cmd_nack", 32'(cmd_nack), 32'd0);
    check_output("rst_eng_abort", 32'(eng_abort), 32'd0);
  endtask

  // Main sequence: directed test-plan cases, then randomized traffic.
  initial begin : main
    int base, g;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    #1 reset = 1'b0;

    zero_wait = 1'b1;
    $display("[TB] zero-wait write and read");
    apply_stimulus(1'b0, 7'h55, 8'hEB, 8'hAD, 0, 8'h00);
    wait_idle();
    check_output("write_latency", 32'(rise_cyc - accept_cyc), 32'd10);
    check_output("req_ready_idle", 32'(req_ready), 32'd1);
    apply_stimulus(1'b1, 7'h55, 8'h10, 8'h00, 0, 8'h3C);
    wait_idle();
    check_output("read_latency", 32'(rise_cyc - accept_cyc), 32'd14);
    apply_stimulus(1'b0, 7'h55, 8'hEB, 8'hAD, 1, 8'h00);
    wait_idle();
    zero_wait = 1'b0;

    $display("[TB] backpressure, response stall, spurious done");
    cmd_stall_force = 5; rsp_stall_force = 3; spur_pct = 100;
    apply_stimulus(1'b0, 7'h12, 8'h34, 8'h56, 0, 8'h00);
    apply_stimulus(1'b1, 7'h2A, 8'h77, 8'h00, 0, 8'hC5);
    wait_idle();
    cmd_stall_force = -1; rsp_stall_force = -1; spur_pct = 30;

    $display("[TB] reset during REG wait");
    base = hs_count;
    hold_at = base + 2;
    apply_stimulus(1'b0, 7'h33, 8'h44, 8'h99, 0, 8'h00);
    g = 0;
    while (hs_count < base + 3 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (hs_count < base + 3) fail_now("reg_issue");
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();
    exp_cmd.delete(); exp_rsp.delete(); ack_q.delete(); rd_q.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    hold_at = -1;
    apply_stimulus(1'b0, 7'h0F, 8'hF0, 8'h5A, 0, 8'h00);
    wait_idle();

`ifdef I2C_SEQ_TIMEOUT_EN
    $display("[TB] watchdog timeout after DEV_W");
    abort_cnt = 0;
    hold_at = hs_count + 1;
    exp_cmd.push_back(enc(OP_START, 8'h00, 1'b0));
    exp_cmd.push_back(enc(OP_WRITE, {7'h41, 1'b0}, 1'b0));
    exp_rsp.push_back({2'b11, 8'h00});
    drive_request(1'b0, 7'h41, 8'h01, 8'h02);
    wait_idle();
    check_output("abort_count", 32'(abort_cnt), 32'd1);
    check_output("abort_delay", 32'(abort_cyc - hs_cyc), 32'd20);
    hold_at = -1;
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      int na;
      na = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      apply_stimulus(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                     na, 8'($urandom));
    end
    wait_idle();
    check_output("req_ready_end", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin : watchdog
    #500000;
    fail_now("global_watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
